// File: rtl/axis_hex_encoder.sv
// rtl/axis_hex_encoder.sv - AXI-Stream binary byte to ASCII hex character encoder
module axis_hex_encoder #(
    parameter bit INCLUDE_CRLF = 1'b1,
    parameter bit SEPARATOR_EN = 1'b1,
    parameter bit UPPERCASE    = 1'b1
) (
    input  logic       axis_aclk,
    input  logic       axis_reset,
    input  logic       s00_axis_tvalid,
    input  logic [7:0] s00_axis_tdata,
    input  logic       s00_axis_tlast,
    output logic       s00_axis_tready,
    output logic       m00_axis_tvalid,
    output logic [7:0] m00_axis_tdata,
    output logic       m00_axis_tlast,
    input  logic       m00_axis_tready
);

    typedef enum logic [2:0] {IDLE, HI, LO, SEP, CR, LF} state_t;

    state_t     state;
    logic [7:0] hold_data;
    logic       hold_last;

    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        if (nib < 4'd10)
            return 8'h30 + {4'h0, nib};
        else
            return (UPPERCASE ? 8'h41 : 8'h61) + {4'h0, nib} - 8'd10;
    endfunction

    // Every output is registered; the next character is loaded on the same
    // edge that retires the current one, so tdata/tlast hold under backpressure.
    always_ff @(posedge axis_aclk) begin
        if (axis_reset) begin
            state           <= IDLE;
            hold_data       <= 8'h00;
            hold_last       <= 1'b0;
            s00_axis_tready <= 1'b0;
            m00_axis_tvalid <= 1'b0;
            m00_axis_tdata  <= 8'h00;
            m00_axis_tlast  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    s00_axis_tready <= 1'b1;
                    if (s00_axis_tvalid && s00_axis_tready) begin
                        hold_data       <= s00_axis_tdata;
                        hold_last       <= s00_axis_tlast;
                        s00_axis_tready <= 1'b0;
                        m00_axis_tvalid <= 1'b1;
                        m00_axis_tdata  <= hex_char(s00_axis_tdata[7:4]);
                        m00_axis_tlast  <= 1'b0;
                        state           <= HI;
                    end
                end
                HI: begin
                    if (m00_axis_tready) begin
                        m00_axis_tdata <= hex_char(hold_data[3:0]);
                        m00_axis_tlast <= hold_last && !INCLUDE_CRLF;
                        state          <= LO;
                    end
                end
                LO: begin
                    if (m00_axis_tready) begin
                        m00_axis_tlast <= 1'b0;
                        if (!hold_last && SEPARATOR_EN) begin
                            m00_axis_tdata <= 8'h20;
                            state          <= SEP;
                        end else if (hold_last && INCLUDE_CRLF) begin
                            m00_axis_tdata <= 8'h0D;
                            state          <= CR;
                        end else begin
                            m00_axis_tvalid <= 1'b0;
                            s00_axis_tready <= 1'b1;
                            state           <= IDLE;
                        end
                    end
                end
                CR: begin
                    if (m00_axis_tready) begin
                        m00_axis_tdata <= 8'h0A;
                        m00_axis_tlast <= 1'b1;
                        state          <= LF;
                    end
                end
                SEP, LF: begin
                    if (m00_axis_tready) begin
                        m00_axis_tvalid <= 1'b0;
                        m00_axis_tlast  <= 1'b0;
                        s00_axis_tready <= 1'b1;
                        state           <= IDLE;
                    end
                end
                default: begin
                    m00_axis_tvalid <= 1'b0;
                    s00_axis_tready <= 1'b0;
                    state           <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_hex_encoder.sv
// tb/tb_axis_hex_encoder.sv - directed bench for axis_hex_encoder (default and lowercase/no-CRLF builds)
module tb_axis_hex_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       sel;
    logic       s_tvalid;
    logic [7:0] s_tdata;
    logic       s_tlast;
    logic       m_tready;

    logic       sr1, mv1, ml1, sr2, mv2, ml2;
    logic [7:0] md1, md2;
    logic       sr, mv, ml;
    logic [7:0] md;

    int checks = 0;
    int passed = 0;
    int failures = 0;

    always #5 clk = ~clk;

    axis_hex_encoder u_def (
        .axis_aclk       (clk),
        .axis_reset      (rst),
        .s00_axis_tvalid (s_tvalid && !sel),
        .s00_axis_tdata  (s_tdata),
        .s00_axis_tlast  (s_tlast),
        .s00_axis_tready (sr1),
        .m00_axis_tvalid (mv1),
        .m00_axis_tdata  (md1),
        .m00_axis_tlast  (ml1),
        .m00_axis_tready (m_tready)
    );

    axis_hex_encoder #(.INCLUDE_CRLF(1'b0), .SEPARATOR_EN(1'b1), .UPPERCASE(1'b0)) u_lc (
        .axis_aclk       (clk),
        .axis_reset      (rst),
        .s00_axis_tvalid (s_tvalid && sel),
        .s00_axis_tdata  (s_tdata),
        .s00_axis_tlast  (s_tlast),
        .s00_axis_tready (sr2),
        .m00_axis_tvalid (mv2),
        .m00_axis_tdata  (md2),
        .m00_axis_tlast  (ml2),
        .m00_axis_tready (m_tready)
    );

    assign sr = sel ? sr2 : sr1;
    assign mv = sel ? mv2 : mv1;
    assign md = sel ? md2 : md1;
    assign ml = sel ? ml2 : ml1;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failures++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input string tag, input logic [7:0] d, input logic l);
        s_tdata  = d;
        s_tlast  = l;
        s_tvalid = 1'b1;
        for (int i = 0; i < 20 && !sr; i++) @(negedge clk);
        check({tag, "_ready"}, 8'(sr), 8'h01);
        @(negedge clk);
        s_tvalid = 1'b0;
    endtask

    task automatic get_beat(input string tag, input logic [7:0] d, input logic l);
        for (int i = 0; i < 20 && !mv; i++) @(negedge clk);
        check({tag, "_valid"}, 8'(mv), 8'h01);
        check({tag, "_data"}, md, d);
        check({tag, "_last"}, 8'(ml), 8'(l));
        @(negedge clk);
    endtask

    initial begin
        sel = 1'b0; s_tvalid = 1'b0; s_tdata = 8'h00; s_tlast = 1'b0;
        m_tready = 1'b1; rst = 1'b1;
        repeat (2) @(negedge clk);

        check("rst_tvalid", 8'(mv1), 8'h00);
        check("rst_tdata",  md1,     8'h00);
        check("rst_tlast",  8'(ml1), 8'h00);
        check("rst_tready", 8'(sr1), 8'h00);
        check("rst_lc_tvalid", 8'(mv2), 8'h00);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_tready", 8'(sr1), 8'h01);

        // single byte 0xA5, tlast
        send_byte("a5", 8'hA5, 1'b1);
        check("a5_latency", 8'(mv1), 8'h01);
        check("a5_busy_tready", 8'(sr1), 8'h00);
        get_beat("a5_hi", 8'h41, 1'b0);
        get_beat("a5_lo", 8'h35, 1'b0);
        get_beat("a5_cr", 8'h0D, 1'b0);
        get_beat("a5_lf", 8'h0A, 1'b1);
        check("a5_idle_tvalid", 8'(mv1), 8'h00);
        check("a5_idle_tready", 8'(sr1), 8'h01);

        // two-byte packet 0x3C, 0x0F(tlast)
        send_byte("p2b0", 8'h3C, 1'b0);
        get_beat("p2_0", 8'h33, 1'b0);
        get_beat("p2_1", 8'h43, 1'b0);
        get_beat("p2_sp", 8'h20, 1'b0);
        send_byte("p2b1", 8'h0F, 1'b1);
        get_beat("p2_2", 8'h30, 1'b0);
        get_beat("p2_3", 8'h46, 1'b0);
        get_beat("p2_cr", 8'h0D, 1'b0);
        get_beat("p2_lf", 8'h0A, 1'b1);

        // backpressure, with a stray upstream byte offered while busy
        m_tready = 1'b0;
        send_byte("bp", 8'hA5, 1'b1);
        s_tvalid = 1'b1; s_tdata = 8'h77; s_tlast = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp_tvalid", 8'(mv1), 8'h01);
            check("bp_tdata",  md1,     8'h41);
            check("bp_tready", 8'(sr1), 8'h00);
            @(negedge clk);
        end
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        get_beat("bp_hi", 8'h41, 1'b0);
        get_beat("bp_lo", 8'h35, 1'b0);
        get_beat("bp_cr", 8'h0D, 1'b0);
        get_beat("bp_lf", 8'h0A, 1'b1);
        check("bp_no_stray", 8'(mv1), 8'h00);

        // reset while LO is pending
        send_byte("mr", 8'h12, 1'b1);
        get_beat("mr_hi", 8'h31, 1'b0);
        check("mr_lo_pending", md1, 8'h32);
        m_tready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_tready = 1'b1;
        check("mr_tvalid", 8'(mv1), 8'h00);
        check("mr_tlast",  8'(ml1), 8'h00);
        @(negedge clk);
        check("mr_tready", 8'(sr1), 8'h01);
        send_byte("mr2", 8'h00, 1'b1);
        get_beat("mr2_hi", 8'h30, 1'b0);
        get_beat("mr2_lo", 8'h30, 1'b0);
        get_beat("mr2_cr", 8'h0D, 1'b0);
        get_beat("mr2_lf", 8'h0A, 1'b1);

        // lowercase, no CR/LF build
        sel = 1'b1;
        @(negedge clk);
        send_byte("lc", 8'hFE, 1'b1);
        get_beat("lc_hi", 8'h66, 1'b0);
        get_beat("lc_lo", 8'h65, 1'b1);
        check("lc_no_crlf", 8'(mv2), 8'h00);
        check("lc_tready", 8'(sr2), 8'h01);
        send_byte("lc2", 8'h9B, 1'b0);
        get_beat("lc2_hi", 8'h39, 1'b0);
        get_beat("lc2_lo", 8'h62, 1'b0);
        get_beat("lc2_sp", 8'h20, 1'b0);
        check("lc2_idle", 8'(mv2), 8'h00);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
